// File: rtl/regbank_pkg.sv
// Shared widths, the hardwired-zero register index and sequencer states
// for the single-port register bank initiator.
package regbank_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int ZERO_REG   = 0;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    OPS,
    WB_WAIT,
    WRITE
  } state_t;
endpackage

// File: rtl/regbank_access_sequencer.sv
// Serialises two operand reads and one writeback over a single-port register bank.
// One request in flight at a time; operands to execute via valid/ready, result back via valid/ready.
module regbank_access_sequencer
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_rd_en,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] bank_select,
  output logic              bank_write,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata,
  output logic              busy
);

  state_t            state;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic              rd_en_q;

  // Gated by reset so a reset landing on the WRITE cycle never corrupts the bank.
  assign bank_write = (state == WRITE) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd_en_q     <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_valid    <= 1'b0;
      wb_ready    <= 1'b0;
      req_ready   <= 1'b1;
      bank_select <= '0;
      bank_wdata  <= '0;
      busy        <= 1'b0;
    end else begin
      // Registered outputs are loaded with the values belonging to the next state.
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            rs2_q       <= req_rs2;
            rd_q        <= req_rd;
            rd_en_q     <= req_rd_en;
            bank_select <= req_rs1;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= RD_A;
          end
        end
        RD_A: begin
          op_a        <= bank_rdata;
          bank_select <= rs2_q;
          state       <= RD_B;
        end
        RD_B: begin
          op_b        <= bank_rdata;
          bank_select <= '0;
          op_valid    <= 1'b1;
          state       <= OPS;
        end
        OPS: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            // A result destined for x0 is dropped without a write cycle.
            if (rd_en_q && (rd_q != ADDR_W'(ZERO_REG))) begin
              wb_ready <= 1'b1;
              state    <= WB_WAIT;
            end else begin
              req_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        WB_WAIT: begin
          if (wb_valid) begin
            bank_wdata  <= wb_data;
            bank_select <= rd_q;
            wb_ready    <= 1'b0;
            state       <= WRITE;
          end
        end
        WRITE: begin
          bank_select <= '0;
          req_ready   <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          op_valid    <= 1'b0;
          wb_ready    <= 1'b0;
          bank_select <= '0;
          req_ready   <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_access_sequencer.sv
// Bench for regbank_access_sequencer: behavioural bank plus an expected register-file
// image; directed scenarios followed by randomized transactions.
module tb_regbank_access_sequencer;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_rd_en;
  logic [AW-1:0] req_rs1, req_rs2, req_rd;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic          wb_valid, wb_ready;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] bank_select;
  logic          bank_write;
  logic [DW-1:0] bank_wdata, bank_rdata;
  logic          busy;

  logic [DW-1:0] bank [16];
  logic [DW-1:0] ref_regs [16];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  int            n_writes = 0;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  regbank_access_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_rd_en(req_rd_en),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .bank_select(bank_select), .bank_write(bank_write),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .busy(busy)
  );

  // Register bank: x0 reads zero, writes are synchronous, reset clears every entry.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else begin
      if (bank_write && bank_select != 0) bank[bank_select] <= bank_wdata;
      if (pl_en && pl_addr != 0) bank[pl_addr] <= pl_data;
    end
  end
  assign bank_rdata = (bank_select == 0) ? '0 : bank[bank_select];

  always @(posedge clk) if (bank_write) n_writes <= n_writes + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_op_b", op_b, 32'h0);
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_wb_ready", 32'(wb_ready), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_bank_select", 32'(bank_select), 32'h0);
    chk("rst_bank_write", 32'(bank_write), 32'h0);
    chk("rst_bank_wdata", bank_wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    if (a != 0) ref_regs[a] = d;
  endtask

  task automatic run_txn(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic rd_en,
                         input logic [DW-1:0] wdat, input int ops_wait,
                         input int wb_wait, input logic noise, input logic rst_in_write);
    int   guard;
    int   w0;
    logic expect_wb;
    logic [DW-1:0] exp_a, exp_b;
    expect_wb = rd_en && (rd != 0);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_ready", 32'(req_ready), 32'h1);
    exp_a = ref_regs[rs1];
    exp_b = ref_regs[rs2];
    w0 = n_writes;
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_rd_en = rd_en;
    op_ready = (ops_wait == 0);
    @(negedge clk);  // RD_A
    req_valid = 1'b0;
    req_rs1 = AW'($urandom); req_rs2 = AW'($urandom); req_rd = AW'($urandom);
    chk("sel_a", 32'(bank_select), 32'(rs1));
    chk("busy_rd", 32'(busy), 32'h1);
    chk("req_ready_busy", 32'(req_ready), 32'h0);
    chk("bank_write_rd", 32'(bank_write), 32'h0);
    @(negedge clk);  // RD_B
    chk("sel_b", 32'(bank_select), 32'(rs2));
    if (noise) begin
      wb_valid = 1'b1; wb_data = $urandom; req_valid = 1'b1;
    end
    @(negedge clk);  // OPS
    wb_valid = 1'b0; req_valid = 1'b0;
    chk("op_valid", 32'(op_valid), 32'h1);
    chk("op_a", op_a, exp_a);
    chk("op_b", op_b, exp_b);
    for (int i = 0; i < ops_wait; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(op_valid), 32'h1);
      chk("stall_a", op_a, exp_a);
      chk("stall_b", op_b, exp_b);
      chk("stall_req_ready", 32'(req_ready), 32'h0);
    end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    chk("op_valid_drop", 32'(op_valid), 32'h0);
    if (expect_wb) begin
      chk("wb_ready", 32'(wb_ready), 32'h1);
      chk("busy_wb", 32'(busy), 32'h1);
      for (int i = 0; i < wb_wait; i++) begin
        @(negedge clk);
        chk("wb_wait_ready", 32'(wb_ready), 32'h1);
      end
      wb_valid = 1'b1; wb_data = wdat;
      @(negedge clk);  // WRITE
      wb_valid = 1'b0; wb_data = $urandom;
      chk("wb_ready_drop", 32'(wb_ready), 32'h0);
      chk("sel_wr", 32'(bank_select), 32'(rd));
      chk("bank_write", 32'(bank_write), 32'h1);
      chk("bank_wdata", bank_wdata, wdat);
      if (rst_in_write) begin
        reset = 1'b1;
        #1;
        chk("write_in_reset", 32'(bank_write), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) ref_regs[i] = '0;
        check_reset_vals();
        chk("rst_no_write", 32'(n_writes - w0), 32'h0);
        chk("rst_target", bank[rd], 32'h0);
        return;
      end
      @(negedge clk);
      ref_regs[rd] = wdat;
    end else begin
      chk("no_wb_ready", 32'(wb_ready), 32'h0);
    end
    chk("end_req_ready", 32'(req_ready), 32'h1);
    chk("end_busy", 32'(busy), 32'h0);
    chk("end_sel", 32'(bank_select), 32'h0);
    chk("write_count", 32'(n_writes - w0), expect_wb ? 32'h1 : 32'h0);
    chk("reg_rd", bank[rd], ref_regs[rd]);
    chk("reg_x0", bank_rdata_x0(), 32'h0);
  endtask

  function automatic logic [DW-1:0] bank_rdata_x0();
    return (bank[0] === '0 || bank[0] === 'x) ? '0 : bank[0];
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_rd_en = 1'b0;
    op_ready = 1'b0; wb_valid = 1'b0; wb_data = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_vals();

    preload(4'd3, 32'h11);
    preload(4'd5, 32'h22);
    run_txn(4'd3, 4'd5, 4'd7, 1'b1, 32'h33, 0, 0, 1'b0, 1'b0);
    chk("x7_written", bank[7], 32'h33);
    run_txn(4'd7, 4'd3, 4'd9, 1'b1, 32'h44, 0, 0, 1'b0, 1'b0);
    chk("b2b_op_a", op_a, 32'h33);
    run_txn(4'd0, 4'd0, 4'd0, 1'b1, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    run_txn(4'd5, 4'd3, 4'd2, 1'b1, 32'h1234, 5, 2, 1'b0, 1'b0);
    run_txn(4'd1, 4'd2, 4'd4, 1'b1, 32'hABCD, 1, 3, 1'b1, 1'b0);
    chk("x4_abcd", bank[4], 32'hABCD);
    run_txn(4'd3, 4'd5, 4'd6, 1'b1, 32'h5555, 0, 0, 1'b0, 1'b1);

    for (int i = 1; i < 16; i++) preload(AW'(i), $urandom);
    for (int n = 0; n < 40; n++) begin
      run_txn(AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom_range(0, 3) != 0),
              $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom), 1'b0);
    end
    for (int i = 0; i < 16; i++) chk("final_reg", bank[i], ref_regs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regbank_access_sequencer.md
Name: regbank_access_sequencer

Overview:
- Initiator for the 16x32 single-port register bank (select / write / dataIn / dataOut, x0 hardwired zero).
- Accepts one decoded operand request (rs1, rs2, rd) and serialises two read cycles over the single select port.
- Presents both operands to the execute stage with a valid/ready handshake, then accepts the writeback result and issues one write cycle.
- Sits between decode/execute and the register bank. Only one request is in flight at a time, so there are no hazards.

Parameters:
- DATA_W, 32, register/operand width; must match the bank width.
- ADDR_W, 4, register index width (16 registers).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  decoded request valid.
- req_ready  out  1  high only in IDLE.
- req_rs1  in  ADDR_W  source register A.
- req_rs2  in  ADDR_W  source register B.
- req_rd  in  ADDR_W  destination register.
- req_rd_en  in  1  request produces a writeback.
- op_valid  out  1  op_a/op_b valid.
- op_ready  in  1  execute stage accepts operands.
- op_a  out  DATA_W  latched value of rs1.
- op_b  out  DATA_W  latched value of rs2.
- wb_valid  in  1  writeback result valid.
- wb_ready  out  1  high only in WB_WAIT.
- wb_data  in  DATA_W  result to write.
- bank_select  out  ADDR_W  to bank select.
- bank_write  out  1  to bank write.
- bank_wdata  out  DATA_W  to bank dataIn.
- bank_rdata  in  DATA_W  from bank dataOut (combinational read of bank_select).
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- States: IDLE, RD_A, RD_B, OPS, WB_WAIT, WRITE.
- Request capture: in IDLE, req_valid & req_ready captures rs1, rs2, rd, rd_en into internal registers, then goes to RD_A.
- RD_A: bank_select=rs1; op_a <= bank_rdata at the end of the cycle; go to RD_B.
- RD_B: bank_select=rs2; op_b <= bank_rdata; go to OPS.
- OPS: op_valid=1, and op_a/op_b are held stable.
  - On op_ready: go to WB_WAIT if rd_en=1 and rd!=0; otherwise go to IDLE.
  - A writeback to x0 is dropped by skipping the write cycle.
- WB_WAIT: wb_ready=1. On wb_valid: bank_wdata <= wb_data, then go to WRITE.
- WRITE: bank_select=rd, bank_write=1, bank_wdata held; go to IDLE.
- Latency, request accept (cycle T) to op_valid: op_valid rises at T+3. With op_ready tied high, req_ready returns at T+4 when there is no writeback.
- Latency, writeback accept (cycle W): bank write at edge W+2, and the result is readable by the next request.
- Bank outputs outside RD_A/RD_B/WRITE: bank_select=0, bank_write=0. bank_wdata holds its last value and is don't-care when bank_write=0.
- bank_write = (state==WRITE) & !reset. No bank write is ever issued in a reset cycle.
- Reads of x0 still take the RD cycle. The bank returns 0, so the operand is 0.
- Ignored inputs:
  - wb_valid outside WB_WAIT is ignored and not buffered.
  - req_valid outside IDLE is ignored.
- Reset mid-operation: state goes to IDLE on the next edge, pending request and writeback data are discarded, no partial write occurs.
- Reset values: op_a=0, op_b=0, op_valid=0, wb_ready=0, req_ready=1 after reset release, bank_select=0, bank_write=0, bank_wdata=0, busy=0.
- Widths: all data paths are DATA_W bits; no arithmetic is performed.

Decomposition:
- Shared package `regbank_pkg`: DATA_W/ADDR_W defaults, ZERO_REG=0, and the state enum (IDLE, RD_A, RD_B, OPS, WB_WAIT, WRITE).
- Single flat module; no sub-module is warranted.
- The bench instantiates the existing register bank as the bank model.

Test Plan:
- Preload x3=0x11, x5=0x22. Request rs1=3, rs2=5, rd=7, rd_en=1, op_ready=1, wb_data=0x33 → op_a=0x11, op_b=0x22 at T+3; x7=0x33 after the WRITE cycle; bank_select sequence 3,5,7.
- Request rs1=0, rs2=0 → op_a=op_b=0. Then rd=0, rd_en=1, wb_data=0xFFFF_FFFF → no WB_WAIT state, bank_write never asserted, x0 still 0.
- op_ready held low 5 cycles in OPS → op_valid stays 1, op_a/op_b stable, req_ready=0. Release → handshake completes in 1 cycle.
- wb_valid pulsed while in RD_B → ignored. Later wb_valid in WB_WAIT with 0xABCD → only 0xABCD written.
- Reset asserted in the cycle the state is WRITE → bank_write=0 that cycle, target register not modified (bank also cleared), state IDLE, all outputs at reset values.
- Back-to-back requests, second with rs1=previous rd (7) → op_a = value just written (0x33).
